// File: rtl/vga_config_loader.sv
// Streams a host-loaded table of (addr, data) pairs to VGA_Control over a
// valid/ready handshake, with a per-entry ready timeout and host abort.

module vga_config_loader #(
    parameter int CONFIG_WIDTH = 4,
    parameter int NUM_ENTRIES  = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                    Clk,
    input  logic                    rst_n,
    input  logic                    H_we,
    input  logic [2:0]              H_idx,
    input  logic [CONFIG_WIDTH-1:0] H_addr,
    input  logic [CONFIG_WIDTH-1:0] H_data,
    input  logic [3:0]              Count,
    input  logic                    Start,
    input  logic                    Abort,
    input  logic                    C_rdy,
    output logic                    C_valid,
    output logic [CONFIG_WIDTH-1:0] C_addr,
    output logic [CONFIG_WIDTH-1:0] C_data,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Err,
    output logic [3:0]              Sent_cnt
);

    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);
    localparam logic [3:0]    MAX_CNT_C = (NUM_ENTRIES > 15) ? 4'd15 : 4'(NUM_ENTRIES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [2*CONFIG_WIDTH-1:0] r_table [NUM_ENTRIES];
    logic [3:0]                r_count;
    logic [IW-1:0]             r_idx;
    logic [TW-1:0]             r_timer;
    logic [CONFIG_WIDTH-1:0]   r_c_addr;
    logic [CONFIG_WIDTH-1:0]   r_c_data;
    logic                      r_err;
    logic                      r_done_zero;
    logic [3:0]                r_sent_cnt;

    logic [IW-1:0]             w_h_idx;
    logic                      w_h_idx_ok;
    logic [3:0]                w_count_in;
    logic                      w_start;
    logic                      w_xfer;
    logic                      w_last;
    logic                      w_timeout_hit;

    assign w_h_idx       = IW'(H_idx);
    assign w_h_idx_ok    = (32'(H_idx) < NUM_ENTRIES);
    assign w_count_in    = (Count > MAX_CNT_C) ? MAX_CNT_C : Count;
    assign w_start       = (r_state == S_IDLE) && Start;
    assign w_xfer        = (r_state == S_SEND) && C_rdy;
    assign w_last        = (4'(r_idx) == (r_count - 4'd1));
    // Abort outranks a timeout landing in the same cycle.
    assign w_timeout_hit = (r_state == S_SEND) && !C_rdy && !Abort && (r_timer == TIMEOUT_C);

    // The reset input is active-high despite its _n suffix.
    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults come first so no path through the block leaves a signal unassigned (no latch).
        w_state_nxt = r_state;
        C_valid     = 1'b0;
        Busy        = 1'b1;
        Done        = r_done_zero;

        case (r_state)
            S_IDLE: begin
                Busy = 1'b0;
                if (Start && (w_count_in != 4'd0)) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                C_valid = 1'b1;
                if (w_xfer) begin
                    w_state_nxt = w_last ? S_DONE : S_FETCH;
                end else if (w_timeout_hit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                Done        = !Abort;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (Abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign C_addr   = r_c_addr;
    assign C_data   = r_c_data;
    assign Err      = r_err | w_timeout_hit;
    assign Sent_cnt = r_sent_cnt;

    always_ff @(posedge Clk) begin
        if (rst_n) begin
            // NOTE: the table is reset explicitly because a reset must leave every entry reading zero.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_table[i] <= '0;
            end
            r_count     <= '0;
            r_idx       <= '0;
            r_timer     <= '0;
            r_c_addr    <= '0;
            r_c_data    <= '0;
            r_err       <= 1'b0;
            r_done_zero <= 1'b0;
            r_sent_cnt  <= '0;
        end else begin
            r_done_zero <= 1'b0;

            if ((r_state == S_IDLE) && H_we && w_h_idx_ok) begin
                r_table[w_h_idx] <= {H_addr, H_data};
            end

            if (w_start) begin
                r_count     <= w_count_in;
                r_idx       <= '0;
                r_timer     <= '0;
                r_err       <= 1'b0;
                r_sent_cnt  <= '0;
                r_done_zero <= (w_count_in == 4'd0);
            end

            if (r_state == S_FETCH) begin
                {r_c_addr, r_c_data} <= r_table[r_idx];
                r_timer              <= '0;
            end

            if (w_xfer) begin
                r_sent_cnt <= r_sent_cnt + 4'd1;
                r_timer    <= '0;
                if (!w_last) begin
                    r_idx <= r_idx + IW'(1);
                end
            end else if (r_state == S_SEND) begin
                r_timer <= r_timer + TW'(1);
                if (w_timeout_hit) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

endmodule
